// File: rtl/mha_sa_defs.sv
// rtl/mha_sa_defs.sv - shared defaults and FSM encoding for the systolic array feeders
package mha_sa_defs;

   // Default array geometry
   localparam int DEF_N     = 16;
   localparam int DEF_DW    = 8;
   localparam int DEF_LEN_W = 16;

   // Feeder FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth data+valid shift register for one skewed lane
module skew_delay_line
   import mha_sa_defs::*;
#(
   parameter int DEPTH = 1,
   parameter int DW    = DEF_DW
) (
   input  logic          I_CLK,
   input  logic          I_RST,
   input  logic [DW-1:0] I_DATA,
   input  logic          I_VALID,
   output logic [DW-1:0] O_DATA,
   output logic          O_VALID
);

   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   // Shift every cycle; there is no stall, bubbles travel as zero/invalid
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
         valid_q <= '0;
      end else begin
         data_q[0]  <= I_DATA;
         valid_q[0] <= I_VALID;
         for (int k = 1; k < DEPTH; k++) begin
            data_q[k]  <= data_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   assign O_DATA  = data_q[DEPTH-1];
   assign O_VALID = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_x_skew_feeder.sv
// rtl/systolic_x_skew_feeder.sv - skews a burst of row vectors into a diagonal wavefront for the PE array
module systolic_x_skew_feeder
   import mha_sa_defs::*;
#(
   parameter int N     = DEF_N,
   parameter int DW    = DEF_DW,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic            I_CLK,
   input  logic            I_RST,
   input  logic            I_START,
   input  logic [LEN_W-1:0] I_LEN,
   input  logic            I_VALID,
   input  logic [N*DW-1:0] I_DATA,
   output logic            O_READY,
   output logic [N*DW-1:0] O_X,
   output logic [N-1:0]    O_X_VALID,
   output logic            O_BUSY,
   output logic            O_DONE
);

   // Flush counter must hold 0..N-1; keep at least one bit for N=1
   localparam int              FC_W       = (N > 1) ? $clog2(N) : 1;
   localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(N - 1);

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat_cnt_q;
   logic [FC_W-1:0]  flush_cnt_q;
   logic             accept;
   logic             last_beat;

   // Accept is derived from the registered state so it never loops through the FSM logic
   assign accept    = I_VALID && (state_q == ST_STREAM);
   assign last_beat = accept && (beat_cnt_q == len_q - LEN_W'(1));

   // State register
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_d = state_q;
      O_READY = 1'b0;
      O_BUSY  = 1'b0;
      O_DONE  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               state_d = (I_LEN != '0) ? ST_STREAM : ST_DONE;
            end
         end
         ST_STREAM: begin
            O_READY = 1'b1;
            O_BUSY  = 1'b1;
            if (last_beat) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            O_BUSY = 1'b1;
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            O_DONE  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Burst length latch, beat counter and flush counter
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         len_q       <= '0;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (I_START && (I_LEN != '0)) begin
                  len_q      <= I_LEN;
                  beat_cnt_q <= '0;
               end
            end
            ST_STREAM: begin
               flush_cnt_q <= '0;
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q + LEN_W'(1);
               end
            end
            ST_FLUSH: begin
               flush_cnt_q <= flush_cnt_q + FC_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Lane i gets i+1 stages so beat t lands on lane i in cycle t+1+i
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] stage0_data;

      assign stage0_data = accept ? I_DATA[i*DW +: DW] : '0;

      skew_delay_line #(
         .DEPTH (i + 1),
         .DW    (DW)
      ) u_line (
         .I_CLK   (I_CLK),
         .I_RST   (I_RST),
         .I_DATA  (stage0_data),
         .I_VALID (accept),
         .O_DATA  (O_X[i*DW +: DW]),
         .O_VALID (O_X_VALID[i])
      );
   end

endmodule

// File: tb/tb_systolic_x_skew_feeder.sv
// tb/tb_systolic_x_skew_feeder.sv - directed self-checking bench for the skew feeder
module tb_systolic_x_skew_feeder;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int LEN_W = 16;

   localparam logic [31:0] B0 = 32'h04030201;
   localparam logic [31:0] B1 = 32'h14131211;
   localparam logic [31:0] B2 = 32'h24232221;
   localparam logic [31:0] JK = 32'hEEEEEEEE;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len   = '0;
   logic             valid = 1'b0;
   logic [N*DW-1:0]  data  = '0;
   logic             ready;
   logic [N*DW-1:0]  x;
   logic [N-1:0]     x_valid;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   systolic_x_skew_feeder #(.N(N), .DW(DW), .LEN_W(LEN_W)) dut (
      .I_CLK     (clk),
      .I_RST     (rst),
      .I_START   (start),
      .I_LEN     (len),
      .I_VALID   (valid),
      .I_DATA    (data),
      .O_READY   (ready),
      .O_X       (x),
      .O_X_VALID (x_valid),
      .O_BUSY    (busy),
      .O_DONE    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check current outputs, advance to #1 after next edge
   task automatic cyc(input string tag, input logic v, input logic [31:0] d,
                      input logic st, input logic [15:0] l,
                      input logic [31:0] ex, input logic [3:0] ev, input logic [2:0] rbd);
      valid = v;
      data  = d;
      start = st;
      len   = l;
      chk({tag, ".x"},     64'(x),       64'(ex));
      chk({tag, ".xv"},    64'(x_valid), 64'(ev));
      chk({tag, ".ready"}, 64'(ready),   64'(rbd[2]));
      chk({tag, ".busy"},  64'(busy),    64'(rbd[1]));
      chk({tag, ".done"},  64'(done),    64'(rbd[0]));
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc("rst", 1, B0, 1, 3, 32'h0, 4'h0, 3'b000);
      rst = 1'b0;

      // Scenario 1: K=3, continuous valid
      cyc("t1.idle", 0, 0,  1, 3, 32'h00000000, 4'b0000, 3'b000);
      cyc("t1.c0",   1, B0, 0, 0, 32'h00000000, 4'b0000, 3'b110);
      cyc("t1.c1",   1, B1, 0, 0, 32'h00000001, 4'b0001, 3'b110);
      cyc("t1.c2",   1, B2, 0, 0, 32'h00000211, 4'b0011, 3'b110);
      cyc("t1.c3",   0, 0,  0, 0, 32'h00031221, 4'b0111, 3'b010);
      cyc("t1.c4",   0, 0,  0, 0, 32'h04132200, 4'b1110, 3'b010);
      cyc("t1.c5",   0, 0,  0, 0, 32'h14230000, 4'b1100, 3'b010);
      cyc("t1.c6",   0, 0,  0, 0, 32'h24000000, 4'b1000, 3'b010);
      cyc("t1.c7",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b001);
      cyc("t1.c8",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b000);

      // Scenario 2: bubble after the first beat
      cyc("t2.idle", 0, 0,  1, 3, 32'h00000000, 4'b0000, 3'b000);
      cyc("t2.c0",   1, B0, 0, 0, 32'h00000000, 4'b0000, 3'b110);
      cyc("t2.c1",   0, B1, 0, 0, 32'h00000001, 4'b0001, 3'b110);
      cyc("t2.c2",   1, B1, 0, 0, 32'h00000200, 4'b0010, 3'b110);
      cyc("t2.c3",   1, B2, 0, 0, 32'h00030011, 4'b0101, 3'b110);
      cyc("t2.c4",   0, 0,  0, 0, 32'h04001221, 4'b1011, 3'b010);
      cyc("t2.c5",   0, 0,  0, 0, 32'h00132200, 4'b0110, 3'b010);
      cyc("t2.c6",   0, 0,  0, 0, 32'h14230000, 4'b1100, 3'b010);
      cyc("t2.c7",   0, 0,  0, 0, 32'h24000000, 4'b1000, 3'b010);
      cyc("t2.c8",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b001);
      cyc("t2.c9",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b000);

      // Scenario 3: zero-length burst
      cyc("t3.idle", 0, 0, 1, 0, 32'h0, 4'b0000, 3'b000);
      cyc("t3.done", 0, 0, 0, 0, 32'h0, 4'b0000, 3'b001);
      cyc("t3.post", 0, 0, 0, 0, 32'h0, 4'b0000, 3'b000);

      // Scenario 4: reset during the second flush cycle, then a clean K=1 burst
      cyc("t4.idle", 0, 0,  1, 3, 32'h00000000, 4'b0000, 3'b000);
      cyc("t4.c0",   1, B0, 0, 0, 32'h00000000, 4'b0000, 3'b110);
      cyc("t4.c1",   1, B1, 0, 0, 32'h00000001, 4'b0001, 3'b110);
      cyc("t4.c2",   1, B2, 0, 0, 32'h00000211, 4'b0011, 3'b110);
      cyc("t4.c3",   0, 0,  0, 0, 32'h00031221, 4'b0111, 3'b010);
      rst = 1'b1;
      cyc("t4.c4",   0, 0,  0, 0, 32'h04132200, 4'b1110, 3'b010);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc($sformatf("t4.rst%0d", k), 0, 0, 0, 0, 32'h0, 4'b0000, 3'b000);
      end
      cyc("t4.n.idle", 0, 0,            1, 1, 32'h00000000, 4'b0000, 3'b000);
      cyc("t4.n.c0",   1, 32'hDDCCBBAA, 0, 0, 32'h00000000, 4'b0000, 3'b110);
      cyc("t4.n.c1",   0, 0,            0, 0, 32'h000000AA, 4'b0001, 3'b010);
      cyc("t4.n.c2",   0, 0,            0, 0, 32'h0000BB00, 4'b0010, 3'b010);
      cyc("t4.n.c3",   0, 0,            0, 0, 32'h00CC0000, 4'b0100, 3'b010);
      cyc("t4.n.c4",   0, 0,            0, 0, 32'hDD000000, 4'b1000, 3'b010);
      cyc("t4.n.c5",   0, 0,            0, 0, 32'h00000000, 4'b0000, 3'b001);
      cyc("t4.n.c6",   0, 0,            0, 0, 32'h00000000, 4'b0000, 3'b000);

      // Scenario 5: stray valid in IDLE, start in STREAM and DONE, valid in FLUSH
      cyc("t5.iv0",  1, JK, 0, 0, 32'h0, 4'b0000, 3'b000);
      cyc("t5.iv1",  1, JK, 0, 0, 32'h0, 4'b0000, 3'b000);
      cyc("t5.idle", 1, JK, 1, 2, 32'h00000000, 4'b0000, 3'b000);
      cyc("t5.c0",   1, B0, 1, 5, 32'h00000000, 4'b0000, 3'b110);
      cyc("t5.c1",   1, B1, 0, 0, 32'h00000001, 4'b0001, 3'b110);
      cyc("t5.c2",   1, JK, 0, 0, 32'h00000211, 4'b0011, 3'b010);
      cyc("t5.c3",   1, JK, 0, 0, 32'h00031200, 4'b0110, 3'b010);
      cyc("t5.c4",   1, JK, 0, 0, 32'h04130000, 4'b1100, 3'b010);
      cyc("t5.c5",   1, JK, 0, 0, 32'h14000000, 4'b1000, 3'b010);
      cyc("t5.c6",   0, 0,  1, 1, 32'h00000000, 4'b0000, 3'b001);

      // Scenario 6: back-to-back start in the IDLE cycle right after DONE
      cyc("t6.idle", 0, 0,  1, 2, 32'h00000000, 4'b0000, 3'b000);
      cyc("t6.c0",   1, B0, 0, 0, 32'h00000000, 4'b0000, 3'b110);
      cyc("t6.c1",   1, B1, 0, 0, 32'h00000001, 4'b0001, 3'b110);
      cyc("t6.c2",   0, 0,  0, 0, 32'h00000211, 4'b0011, 3'b010);
      cyc("t6.c3",   0, 0,  0, 0, 32'h00031200, 4'b0110, 3'b010);
      cyc("t6.c4",   0, 0,  0, 0, 32'h04130000, 4'b1100, 3'b010);
      cyc("t6.c5",   0, 0,  0, 0, 32'h14000000, 4'b1000, 3'b010);
      cyc("t6.c6",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b001);
      cyc("t6.c7",   0, 0,  0, 0, 32'h00000000, 4'b0000, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
